// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and the baud-rate divider.
package uart_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Divider counter width: clog2 of the bit period, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between a producer and the UART transmitter.
interface uart_tx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: bit_done pulses on the last clk cycle of every serial bit.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_done
);
    import uart_pkg::*;

    localparam int CW = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_reg;

    assign bit_done = (cnt_reg == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear || bit_done) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_W bits LSB-first, optional parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to add the break_req input (hold tx low while idle).
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int PARITY       = 0
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_param_if.slave   bus,
`ifdef UART_TX_BREAK_EN
    input  logic             break_req,
`endif
    output logic             tx,
    output logic             busy
);

    uart_state_t       state_reg;
    logic [DATA_W-1:0] shreg_reg;
    logic              par_reg;
    logic [3:0]        bit_cnt_reg;
    logic              tx_reg;
    logic              ready_reg;
    logic              busy_reg;
    logic              bit_done;
    logic              brk;

`ifdef UART_TX_BREAK_EN
    assign brk = break_req;
`else
    assign brk = 1'b0;
`endif

    // Divider is held at zero in IDLE so every frame starts with a full start bit.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_reg == S_IDLE),
        .bit_done (bit_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            shreg_reg   <= '0;
            par_reg     <= 1'b0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            ready_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.tx_valid && ready_reg) begin
                        shreg_reg   <= bus.tx_data;
                        par_reg     <= (^bus.tx_data) ^ (PARITY == PAR_ODD);
                        bit_cnt_reg <= '0;
                        state_reg   <= S_START;
                        tx_reg      <= 1'b0;
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                    end else begin
                        tx_reg    <= ~brk;
                        ready_reg <= ~brk;
                    end
                end
                S_START: begin
                    if (bit_done) begin
                        state_reg <= S_DATA;
                        tx_reg    <= shreg_reg[0];
                    end
                end
                S_DATA: begin
                    if (bit_done) begin
                        if (bit_cnt_reg == 4'(DATA_W - 1)) begin
                            bit_cnt_reg <= '0;
                            if (PARITY != PAR_NONE) begin
                                state_reg <= S_PARITY;
                                tx_reg    <= par_reg;
                            end else begin
                                state_reg <= S_STOP;
                                tx_reg    <= 1'b1;
                            end
                        end else begin
                            // Next bit is shreg[1]; present it while shifting it into place.
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            tx_reg      <= shreg_reg[1];
                            shreg_reg   <= shreg_reg >> 1;
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_done) begin
                        state_reg   <= S_STOP;
                        tx_reg      <= 1'b1;
                        bit_cnt_reg <= '0;
                    end
                end
                S_STOP: begin
                    if (bit_done) begin
                        if (bit_cnt_reg == 4'(STOP_BITS - 1)) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                            tx_reg    <= ~brk;
                            ready_reg <= ~brk;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    tx_reg    <= 1'b1;
                    ready_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign tx           = tx_reg;
    assign busy         = busy_reg;
    assign bus.tx_ready = ready_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four configurations, hand-computed serial frames.
module tb_uart_tx_param;

    localparam int NG = 4;
`ifdef UART_TX_BREAK_EN
    localparam int NV = 10;
`else
    localparam int NV = 9;
`endif

    typedef struct {
        int         inst;
        logic [8:0] data;
        logic [15:0] pat;
        bit         chain;
        int         gap;
        int         rst_at;
        int         brk_cyc;
    } vec_t;

    typedef struct {
        logic [15:0] pat;
        bit          abort;
        int          gap;
    } exp_t;

    logic clk;
    int vecs = 0;
    int errs = 0;
    int n_done = 0;
    int cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cfg_dw(input int i);
        return (i == 3) ? 5 : 8;
    endfunction
    function automatic int cfg_cpb(input int i);
        return (i == 3) ? 1 : 4;
    endfunction
    function automatic int cfg_stop(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
    endfunction

    // Serial patterns: bit k is the line level of serial bit k (start first).
    function automatic vec_t vec(input int i);
        vec_t v;
        v.inst = 0; v.data = 9'h0; v.pat = 16'h0; v.chain = 1'b0;
        v.gap = 0; v.rst_at = 0; v.brk_cyc = 0;
        case (i)
            0: begin v.inst = 0; v.data = 9'h0A5; v.pat = 16'h034A; end
            1: begin v.inst = 0; v.data = 9'h000; v.pat = 16'h0200; v.chain = 1'b1; end
            2: begin v.inst = 0; v.data = 9'h0FF; v.pat = 16'h03FE; v.gap = 41; end
            3: begin v.inst = 0; v.data = 9'h055; v.rst_at = 14; end
            4: begin v.inst = 0; v.data = 9'h00F; v.pat = 16'h021E; end
            5: begin v.inst = 1; v.data = 9'h0A5; v.pat = 16'h054A; end
            6: begin v.inst = 1; v.data = 9'h001; v.pat = 16'h0602; end
            7: begin v.inst = 2; v.data = 9'h0A5; v.pat = 16'h074A; end
            8: begin v.inst = 3; v.data = 9'h015; v.pat = 16'h00EA; end
            default: begin v.inst = 0; v.data = 9'h03C; v.pat = 16'h0278; v.brk_cyc = 10; end
        endcase
        return v;
    endfunction

    function automatic void chk(input int inst, input string name,
                                input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL u%0d %s: got 0x%0h, expected 0x%0h", inst, name, act, req);
        end
    endfunction

    for (genvar gi = 0; gi < NG; gi++) begin : g
        localparam int DW   = cfg_dw(gi);
        localparam int CPB  = cfg_cpb(gi);
        localparam int STP  = cfg_stop(gi);
        localparam int PAR  = cfg_par(gi);
        localparam int F    = CPB * (1 + DW + ((PAR != 0) ? 1 : 0) + STP);

        logic rst_b;
        logic tx_w;
        logic busy_w;
`ifdef UART_TX_BREAK_EN
        logic brk;
`endif
        exp_t sb[$];
        int hs_cnt = 0;

        uart_tx_param_if #(.DATA_W(DW)) bus ();

        uart_tx_param #(
            .DATA_W       (DW),
            .CLKS_PER_BIT (CPB),
            .STOP_BITS    (STP),
            .PARITY       (PAR)
        ) dut (
            .clk       (clk),
            .rst       (rst_b),
            .bus       (bus),
`ifdef UART_TX_BREAK_EN
            .break_req (brk),
`endif
            .tx        (tx_w),
            .busy      (busy_w)
        );

        always @(posedge clk) begin
            if (bus.tx_valid && bus.tx_ready) hs_cnt <= hs_cnt + 1;
        end

        // Driver: issues vectors and pushes the expected frame for each.
        initial begin : drv
            vec_t v;
            exp_t e;
            int t;
            int hs_exp;
            hs_exp = 0;
            bus.tx_valid = 1'b0;
            bus.tx_data  = '0;
            rst_b = 1'b1;
`ifdef UART_TX_BREAK_EN
            brk = 1'b0;
`endif
            repeat (3) @(negedge clk);
            chk(gi, "reset_state", {tx_w, bus.tx_ready, busy_w}, 3'b100);
            rst_b = 1'b0;
            @(negedge clk);
            chk(gi, "ready_after_reset", bus.tx_ready, 1);
            for (int i = 0; i < NV; i++) begin
                v = vec(i);
                if (v.inst == gi) begin
                    hs_exp++;
`ifdef UART_TX_BREAK_EN
                    if (v.brk_cyc > 0) begin
                        brk = 1'b1;
                        for (int k = 0; k < v.brk_cyc; k++) begin
                            @(negedge clk);
                            if (k == 0) begin
                                bus.tx_data  = v.data[DW-1:0];
                                bus.tx_valid = 1'b1;
                            end
                            chk(gi, "break_line", {tx_w, bus.tx_ready}, 2'b00);
                        end
                        brk = 1'b0;
                        @(negedge clk);
                        chk(gi, "break_release", {tx_w, bus.tx_ready}, 2'b11);
                    end
`endif
                    bus.tx_data  = v.data[DW-1:0];
                    bus.tx_valid = 1'b1;
                    e.pat = v.pat; e.abort = (v.rst_at > 0); e.gap = v.gap;
                    sb.push_back(e);
                    t = 0;
                    while (!bus.tx_ready && t < 1000) begin
                        @(negedge clk);
                        t++;
                    end
                    chk(gi, "handshake_wait", (t < 1000), 1);
                    @(posedge clk);
                    @(negedge clk);
                    chk(gi, "frame_started", {busy_w, tx_w, bus.tx_ready}, 3'b100);
                    if (!v.chain) begin
                        bus.tx_valid = 1'b0;
                        bus.tx_data  = ~v.data[DW-1:0];
                    end
                    if (v.rst_at > 0) begin
                        repeat (v.rst_at - 1) @(negedge clk);
                        rst_b = 1'b1;
                        @(negedge clk);
                        chk(gi, "reset_abort", {tx_w, busy_w, bus.tx_ready}, 3'b100);
                        rst_b = 1'b0;
                        @(negedge clk);
                        chk(gi, "ready_after_abort", bus.tx_ready, 1);
                    end
                end
            end
            t = 0;
            while (sb.size() != 0 && t < 2000) begin
                @(negedge clk);
                t++;
            end
            chk(gi, "scoreboard_drained", sb.size(), 0);
            chk(gi, "handshake_count", hs_cnt, hs_exp);
            n_done++;
        end

        // Monitor: captures every frame the line carries and checks it against the queue.
        initial begin : mon
            exp_t e;
            logic [63:0] lv;
            logic [63:0] explv;
            logic prev_busy;
            int n;
            int st;
            int last_start;
            bit ab;
            prev_busy = 1'b0;
            last_start = -100000;
            forever begin
                @(negedge clk);
                if (busy_w && !prev_busy) begin
                    st = cyc;
                    lv = '0;
                    n = 0;
                    ab = 1'b0;
                    while (n < F && !ab) begin
                        if (!busy_w) begin
                            ab = 1'b1;
                        end else begin
                            lv[n] = tx_w;
                            n++;
                            @(negedge clk);
                        end
                    end
                    if (sb.size() == 0) begin
                        chk(gi, "sb_depth", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk(gi, "aborted", ab, e.abort);
                        if (!ab) begin
                            explv = '0;
                            for (int c = 0; c < F; c++) explv[c] = e.pat[c / CPB];
                            chk(gi, "frame_bits", lv, explv);
                            chk(gi, "idle_after", {busy_w, tx_w, bus.tx_ready}, 3'b011);
                            if (e.gap != 0) chk(gi, "start_gap", st - last_start, e.gap);
                        end else begin
                            chk(gi, "abort_line", {busy_w, tx_w}, 2'b01);
                        end
                    end
                    last_start = st;
                end
                prev_busy = busy_w;
            end
        end
    end

    initial begin : fin
        int t;
        t = 0;
        while (n_done < NG && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk(-1, "all_blocks_done", n_done, NG);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART serial transmitter. Successor to the fixed 8N1 transmitter.
- Converts parallel words into asynchronous serial frames: start bit, DATA_W data bits LSB-first, optional parity, 1 or 2 stop bits.
- Bit timing comes from a clock-enable divider on the system clock; no internally generated clock.
- Sits between any valid/ready producer (CPU register, FIFO) and the board TX pin.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal >=1.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- tx_data  in  DATA_W  word to send; sampled only on handshake.
- tx_valid  in  1  producer has a word.
- tx_ready  out  1  block can accept a word; high only in IDLE.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a frame is in flight (any state but IDLE).

Behaviour:
- Reset (rst high at a clock edge), effective at that edge:
  - tx=1, tx_ready=0, busy=0, state=IDLE, bit counter=0, divider=0.
  - tx_ready rises the first cycle rst is low.
- Reset mid-frame aborts the frame immediately. tx returns high at that edge; there is no partial stop bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, tx_ready=1.
  - On tx_valid && tx_ready, latch tx_data and compute parity from the latched word, then go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shreg[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
  - After DATA_W bits, go to PARITY if PARITY!=0, else STOP.
- PARITY:
  - tx = XOR of data bits (even mode), or its inverse (odd mode), for CLKS_PER_BIT cycles; then STOP.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Divider:
  - Counts 0..CLKS_PER_BIT-1 and is cleared on every state entry.
  - A bit ends when the count reaches CLKS_PER_BIT-1.
  - Width is clog2(CLKS_PER_BIT), minimum 1.
- Latency: tx falls on the clock edge after the handshake edge.
- Frame length F = CLKS_PER_BIT*(1+DATA_W+(PARITY!=0)+STOP_BITS) cycles.
- Back-to-back traffic: with tx_valid held high, consecutive start bits are F+1 cycles apart (one IDLE cycle between frames).
- Changes to tx_data or tx_valid while busy have no effect on the frame. tx_valid high during busy is held off by tx_ready=0; no word is lost or duplicated.
- tx is a registered output; no glitches.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Defined:
  - Adds input port break_req (1 bit).
  - In IDLE, break_req=1 forces tx=0 and tx_ready=0 for as long as it is held.
  - A break_req asserted mid-frame is ignored until the frame completes.
  - Releasing it gives one cycle of tx=1 in IDLE before any new handshake is accepted.
- Undefined: no port, and behaviour is exactly as above.

Decomposition:
- Package uart_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Parity mode constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2.
- Sub-module uart_baud_gen:
  - Parametrised by CLKS_PER_BIT.
  - Inputs clk, rst, clear; output bit_done pulse on the last cycle of each bit.
  - Reused by the future receiver.

Test Plan:
- 8N1 single frame (DATA_W=8, CLKS_PER_BIT=4, PARITY=0, STOP_BITS=1): send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit for 4 cycles. busy is high for 40 cycles, then tx_ready=1.
- Parity modes, 0xA5:
  - PARITY=1 -> parity bit 0.
  - PARITY=2 -> parity bit 1.
  - Either mode -> frame length 44 cycles.
  - Also 0x01 with PARITY=1 -> parity bit 1.
- Back-to-back: tx_valid held with 0x00 then 0xFF, CLKS_PER_BIT=4 -> start bits 41 cycles apart. The second frame's data bits are all 1. Exactly two handshakes occur.
- Mid-frame reset: rst pulsed 1 cycle during the 3rd data bit of 0x55 -> tx=1 and busy=0 at that edge, tx_ready=1 the next cycle. The next frame (0x0F) is sent complete and correct.
- Edge config (DATA_W=5, CLKS_PER_BIT=1, STOP_BITS=2): send 0x15 -> tx = 0,1,0,1,0,1,1,1, one cycle per bit; busy lasts 8 cycles.
- With UART_TX_BREAK_EN: break_req held 10 cycles in IDLE while tx_valid=1 -> tx=0 and tx_ready=0 for those 10 cycles. After release, one idle-high cycle, then the frame starts.
